// File: rtl/imm_ext_stage_pkg.sv
// Shared definitions for the decode-stage immediate generator: format codes,
// skid-buffer state encoding and the XLEN legality check.
package imm_ext_stage_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6,
    FMT_N = 3'd7
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extractor: instruction bits [31:7] plus format code
// in, XLEN-wide sign- or zero-extended immediate out.
module imm_ext_core
  import imm_ext_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     ins,
  input  logic [2:0]      type_code,
  output logic [XLEN-1:0] imm
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_ext_core: XLEN must be 32 or 64");
  end

  logic [31:7] instr;
  logic [31:0] imm32;
  imm_fmt_e    fmt;

  assign instr = ins;
  assign fmt   = imm_fmt_e'(type_code);

  // Every signed format is a 32-bit value whose bit 31 is the instruction sign
  // bit, so widening to 64 bits is a plain sign extension of that value.
  always_comb begin
    imm32 = '0;
    imm   = '0;
    case (fmt)
      FMT_I:   imm32 = {{21{instr[31]}}, instr[30:20]};
      FMT_S:   imm32 = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'h000};
      FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    if (fmt == FMT_Z) begin
      imm[4:0] = instr[19:15];
    end else begin
      imm       = {XLEN{imm32[31]}};
      imm[31:0] = imm32;
    end
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer and a
// sideband tag; every output comes straight from a flop.
module imm_ext_stage
  import imm_ext_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [24:0]          INS,
  input  logic [2:0]           TYPE,
  input  logic [TAG_WIDTH-1:0] TAG_IN,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [XLEN-1:0]      IMM,
  output logic [TAG_WIDTH-1:0] TAG_OUT
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_ext_stage: XLEN must be 32 or 64");
  end

  skid_state_e          state_q, state_d;
  logic [XLEN-1:0]      ext_imm, m_imm_q, k_imm_q;
  logic [TAG_WIDTH-1:0] m_tag_q, k_tag_q;
  logic                 in_ready_q, out_valid_q;
  logic                 accept, drain;
  logic                 load_m_in, load_m_k, load_k;

  imm_ext_core #(.XLEN(XLEN)) u_core (
    .ins       (INS),
    .type_code (TYPE),
    .imm       (ext_imm)
  );

  assign accept = IN_VALID & in_ready_q;
  assign drain  = out_valid_q & OUT_READY;

  // Flush wins over everything, including an input offered in the same cycle.
  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_k  = 1'b0;
    load_k    = 1'b0;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_m_in = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            load_m_in = 1'b1;
          end else if (accept) begin
            load_k  = 1'b1;
            state_d = ST_TWO;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            load_m_k = 1'b1;
            state_d  = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_imm_q     <= '0;
      m_tag_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      if (load_m_in) begin
        m_imm_q <= ext_imm;
        m_tag_q <= TAG_IN;
      end else if (load_m_k) begin
        m_imm_q <= k_imm_q;
        m_tag_q <= k_tag_q;
      end
    end
  end

  // The skid entry is only ever read when the state says it is valid.
  always_ff @(posedge CLK) begin
    if (load_k) begin
      k_imm_q <= ext_imm;
      k_tag_q <= TAG_IN;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign IMM       = m_imm_q;
  assign TAG_OUT   = m_tag_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: XLEN=32 and XLEN=64 instances share one input
// stream and are checked against a FIFO scoreboard of held entries.
module tb_imm_ext_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [24:0] ins;
  logic [2:0]  type_code;
  logic [31:0] tag_in;
  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;

  always #5 clk = ~clk;

  imm_ext_stage #(.XLEN(32), .TAG_WIDTH(32)) dut32 (
    .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready32),
    .INS(ins), .TYPE(type_code), .TAG_IN(tag_in), .OUT_VALID(out_valid32),
    .OUT_READY(out_ready), .IMM(imm32), .TAG_OUT(tag32)
  );

  imm_ext_stage #(.XLEN(64), .TAG_WIDTH(32)) dut64 (
    .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready64),
    .INS(ins), .TYPE(type_code), .TAG_IN(tag_in), .OUT_VALID(out_valid64),
    .OUT_READY(out_ready), .IMM(imm64), .TAG_OUT(tag64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] exp32;
    logic [63:0] exp64;
  } vec_t;

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [31:0] tag;
  } exp_t;

  vec_t        vecs[11];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_exp32;
  logic [63:0] cur_exp64;
  logic        accepted;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic setVec(input int i, input logic [31:0] tag);
    ins       = vecs[i].instr[31:7];
    type_code = vecs[i].fmt;
    cur_exp32 = vecs[i].exp32;
    cur_exp64 = vecs[i].exp64;
    tag_in    = tag;
    in_valid  = 1'b1;
  endtask

  // One clock: compare held state against the scoreboard, update it, step.
  task automatic applyStimulus(output logic acc);
    logic drain;
    exp_t e;
    checkOutput("out_valid32", 64'(out_valid32), 64'(sb.size() > 0));
    checkOutput("out_valid64", 64'(out_valid64), 64'(sb.size() > 0));
    checkOutput("in_ready32", 64'(in_ready32), 64'(sb.size() < 2));
    checkOutput("in_ready64", 64'(in_ready64), 64'(sb.size() < 2));
    if (sb.size() > 0) begin
      checkOutput("imm32", 64'(imm32), 64'(sb[0].imm32));
      checkOutput("imm64", imm64, sb[0].imm64);
      checkOutput("tag32", 64'(tag32), 64'(sb[0].tag));
      checkOutput("tag64", 64'(tag64), 64'(sb[0].tag));
    end
    drain = (sb.size() > 0) && out_ready;
    acc   = in_valid && (sb.size() < 2);
    if (flush) begin
      sb.delete();
      acc = 1'b0;
    end else begin
      if (drain) void'(sb.pop_front());
      if (acc) begin
        e.imm32 = cur_exp32;
        e.imm64 = cur_exp64;
        e.tag   = tag_in;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drainAll();
    logic acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10 && sb.size() > 0; n++) applyStimulus(acc);
    checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
    applyStimulus(acc);
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[1]  = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000};
    vecs[2]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
    vecs[3]  = '{32'h340FD0F3, 3'd6, 32'h0000001F, 64'h000000000000001F};
    vecs[4]  = '{32'h340FD0F3, 3'd0, 32'h00000000, 64'h0000000000000000};
    vecs[5]  = '{32'h340FD0F3, 3'd7, 32'h00000000, 64'h0000000000000000};
    vecs[6]  = '{32'hFE20AC23, 3'd2, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8};
    vecs[7]  = '{32'h008000EF, 3'd5, 32'h00000008, 64'h0000000000000008};
    vecs[8]  = '{32'h123452B7, 3'd4, 32'h12345000, 64'h0000000012345000};
    vecs[9]  = '{32'h7FF00093, 3'd1, 32'h000007FF, 64'h00000000000007FF};
    vecs[10] = '{32'hFFF00093, 3'd6, 32'h00000000, 64'h0000000000000000};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ins = '0; type_code = '0; tag_in = '0; cur_exp32 = '0; cur_exp64 = '0;
    #3;
    checkOutput("rst_out_valid32", 64'(out_valid32), 64'd0);
    checkOutput("rst_in_ready32", 64'(in_ready32), 64'd1);
    checkOutput("rst_imm64", imm64, 64'd0);
    checkOutput("rst_tag32", 64'(tag32), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] table vectors, full throughput");
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      setVec(i, 32'hA000_0000 + 32'(i));
      applyStimulus(accepted);
      checkOutput("table_accept", 64'(accepted), 64'd1);
    end
    drainAll();

    $display("[TB] back-pressure A B C");
    out_ready = 1'b0;
    setVec(0, 32'h0000_000A);
    applyStimulus(accepted);
    setVec(2, 32'h0000_000B);
    applyStimulus(accepted);
    setVec(6, 32'h0000_000C);
    for (int n = 0; n < 3; n++) applyStimulus(accepted);
    checkOutput("c_held", 64'(accepted), 64'd0);
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int n = 0; n < 10 && !accepted; n++) applyStimulus(accepted);
    checkOutput("c_accept_timeout", 64'(accepted), 64'd1);
    drainAll();

    $display("[TB] flush in TWO and in ONE");
    out_ready = 1'b0;
    setVec(1, 32'h0000_0F01);
    applyStimulus(accepted);
    setVec(3, 32'h0000_0F02);
    applyStimulus(accepted);
    setVec(7, 32'h0000_0DEA);
    flush = 1'b1;
    applyStimulus(accepted);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) applyStimulus(accepted);
    setVec(8, 32'h0000_0F03);
    applyStimulus(accepted);
    setVec(9, 32'h0000_0DEB);
    flush = 1'b1;
    applyStimulus(accepted);
    flush = 1'b0;
    in_valid = 1'b0;
    for (int n = 0; n < 3; n++) applyStimulus(accepted);

    $display("[TB] reset mid-transfer");
    out_ready = 1'b0;
    setVec(2, 32'h0000_0E01);
    applyStimulus(accepted);
    in_valid = 1'b0;
    applyStimulus(accepted);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid32", 64'(out_valid32), 64'd0);
    checkOutput("midrst_out_valid64", 64'(out_valid64), 64'd0);
    checkOutput("midrst_in_ready32", 64'(in_ready32), 64'd1);
    checkOutput("midrst_imm32", 64'(imm32), 64'd0);
    checkOutput("midrst_imm64", imm64, 64'd0);
    checkOutput("midrst_tag64", 64'(tag64), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    setVec(1, 32'h0000_0E02);
    applyStimulus(accepted);
    in_valid = 1'b0;
    applyStimulus(accepted);
    applyStimulus(accepted);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
- Registered, parametrised immediate-generation stage for the decode pipeline.
- Extracts and sign- or zero-extends the immediate from instruction bits [31:7] to XLEN bits, selected by a 3-bit format code.
- Carries a sideband tag (PC/ROB id) alongside the immediate, behind valid/ready handshakes with a 2-entry skid buffer.
- Adds over the previous generation: XLEN generalisation (32/64), CSR zimm (Z-type), back-pressure, and flush.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64 only, any other value is an elaboration error.
- TAG_WIDTH, 32, width of the sideband tag passed through unchanged.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- FLUSH  in  1  synchronous kill of all held entries.
- IN_VALID  in  1  upstream offers an instruction.
- IN_READY  out  1  stage can accept an instruction this cycle.
- INS  in  25  instruction bits [31:7].
- TYPE  in  3  immediate format code.
- TAG_IN  in  TAG_WIDTH  sideband tag.
- OUT_VALID  out  1  IMM/TAG_OUT are valid.
- OUT_READY  in  1  downstream accepts the output.
- IMM  out  XLEN  extended immediate.
- TAG_OUT  out  TAG_WIDTH  tag paired with IMM.

Behaviour:
- Format codes: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, N=7.
- Immediates, with s = INS[31] replicated up to XLEN:
  - I: s, INS[30:20]
  - S: s, INS[30:25], INS[11:7]
  - B: s, INS[7], INS[30:25], INS[11:8], 0
  - U: s (bits XLEN-1:32, XLEN=64 only), INS[31:12], 12'h000
  - J: s, INS[19:12], INS[20], INS[30:21], 0
  - Z: zero-extend INS[19:15]
  - R, N: 0
- Extension is computed combinationally at the input and registered; all outputs are driven from registers (no combinational IN to OUT path).
- Storage: main register M (drives outputs) and skid register K.
- States:
  - EMPTY: M and K invalid.
  - ONE: M valid, K invalid.
  - TWO: M and K valid.
- Handshake signals:
  - IN_READY = (state != TWO), registered.
  - Accept = IN_VALID & IN_READY.
  - Drain = OUT_VALID & OUT_READY.
- Transitions:
  - EMPTY: accept -> ONE (M loaded).
  - ONE: accept & drain -> ONE (M reloaded); accept & !drain -> TWO (K loaded); !accept & drain -> EMPTY.
  - TWO: drain -> ONE (M <- K); no accept is possible in TWO.
- Latency: 1 cycle from accept to OUT_VALID when empty. Throughput: 1 per cycle while OUT_READY=1.
- Ordering is strictly FIFO. IMM/TAG_OUT are held stable while OUT_VALID & !OUT_READY.
- FLUSH has priority over accept and drain:
  - next state EMPTY; an input offered in the same cycle is dropped;
  - IN_READY=1 on the following cycle.
- Reset, including assertion mid-transfer, immediately gives:
  - OUT_VALID=0, IN_READY=1, IMM=0, TAG_OUT=0, state EMPTY.
- Data registers K are not reset. OUT_VALID must never be X after reset.

Decomposition:
- PipelineParams.vh holds:
  - format-code constants (R..N);
  - state encoding EMPTY=0, ONE=1, TWO=2;
  - the XLEN legal-value check macro.
- Natural sub-module: imm_ext_core, a purely combinational XLEN-parametrised extractor (INS, TYPE -> IMM), instantiated once ahead of the registers and unit-testable alone.
- The skid/handshake logic stays in imm_ext_stage.

Test Plan:
- I-type, XLEN=32: INS=0xFFF00093>>7, TYPE=1, OUT_READY=1 -> IMM=0xFFFFFFFF one cycle later; with XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- U and B: lui 0x80000 (0x800000B7), XLEN=64 -> IMM=0xFFFFFFFF80000000; beq -4 (0xFE000EE3), TYPE=3 -> IMM=0xFFFFFFFC (XLEN=32).
- Z and R: csrrwi with rs1 field 31, TYPE=6 -> IMM=0x1F; same INS with TYPE=0 -> 0.
- Back-pressure: OUT_READY=0, offer tags A, B, C back-to-back:
  - A and B are accepted; IN_READY=0 from the cycle after B's accept; C is held.
  - Raise OUT_READY -> outputs A, B, C in order, each stable until drained.
- FLUSH in state TWO with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1; the offered item never appears at the output.
- Assert RST while OUT_VALID=1 -> OUT_VALID=0 and IMM=0 without waiting for a CLK edge; after release, a single item flows with 1-cycle latency.
